// File: rtl/sysbus_mem_responder_pkg.sv
// ============================================================================
// Module  : sysbus_mem_responder_pkg
// Brief   : Shared Sysbus tag layout, line geometry and responder FSM codes.
// Revision: 1.0
// ============================================================================
`default_nettype none

package sysbus_mem_responder_pkg;

    localparam int         c_TAG_RW_BIT       = 12;
    localparam int         c_TAG_TYPE_MSB     = 11;
    localparam int         c_TAG_TYPE_LSB     = 8;
    localparam logic       c_TAG_READ         = 1'b1;
    localparam logic       c_TAG_WRITE        = 1'b0;
    localparam logic [3:0] c_TYPE_MEMORY      = 4'h1;

    localparam int         c_LINE_BYTES       = 64;
    localparam int         c_BEATS_PER_LINE   = 8;
    localparam int         c_LINE_OFFSET_BITS = 6;
    localparam int         c_WORD_SHIFT       = 3;

    typedef logic [2:0] state_t;
    localparam state_t c_ST_IDLE  = 3'd0;
    localparam state_t c_ST_ACK   = 3'd1;
    localparam state_t c_ST_WAIT  = 3'd2;
    localparam state_t c_ST_RESP  = 3'd3;
    localparam state_t c_ST_WDATA = 3'd4;

endpackage

`default_nettype wire

// File: rtl/sysbus_mem_responder_if.sv
// ============================================================================
// Module  : sysbus_mem_responder_if
// Brief   : Sysbus request/response bundle with initiator and target views.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface sysbus_mem_responder_if #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13
) ();

    logic                      bus_reqcyc;
    logic [BUS_DATA_WIDTH-1:0] bus_req;
    logic [BUS_TAG_WIDTH-1:0]  bus_reqtag;
    logic                      bus_reqack;
    logic                      bus_respcyc;
    logic [BUS_DATA_WIDTH-1:0] bus_resp;
    logic [BUS_TAG_WIDTH-1:0]  bus_resptag;
    logic                      bus_respack;

    modport master (
        output bus_reqcyc, bus_req, bus_reqtag, bus_respack,
        input  bus_reqack, bus_respcyc, bus_resp, bus_resptag
    );

    modport slave (
        input  bus_reqcyc, bus_req, bus_reqtag, bus_respack,
        output bus_reqack, bus_respcyc, bus_resp, bus_resptag
    );

endinterface

`default_nettype wire

// File: rtl/sysbus_mem_responder_mem_array.sv
// ============================================================================
// Module  : sysbus_mem_array
// Brief   : Backing store: one synchronous write port, one combinational read.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sysbus_mem_array #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4096,
    parameter int ADDR_W     = 12
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_W-1:0]     i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_W-1:0]     i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    // No reset on the array: contents survive a bus reset.
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/sysbus_mem_responder.sv
// ============================================================================
// Module  : sysbus_mem_responder
// Brief   : Sysbus target serving 64-byte line reads/writes from local memory.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sysbus_mem_responder
    import sysbus_mem_responder_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int MEM_WORDS      = 4096,
    parameter int LATENCY        = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    sysbus_mem_responder_if.slave bus
);

    localparam int c_LAT_W  = $clog2(LATENCY + 1);
    localparam int c_ADDR_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    state_t                    r_state;
    state_t                    w_state_next;
    logic [BUS_DATA_WIDTH-1:0] r_base;
    logic [BUS_TAG_WIDTH-1:0]  r_tag;
    logic [2:0]                r_beat;
    logic [c_LAT_W-1:0]        r_lat_cnt;

    logic [63:0]               w_word_idx;
    logic                      w_is_read;
    logic                      w_mem_hit;
    logic                      w_last_beat;
    logic                      w_lat_done;
    logic                      w_rd_adv;
    logic                      w_wr_adv;
    logic                      w_mem_we;
    logic [BUS_DATA_WIDTH-1:0] w_mem_rdata;
    logic                      w_reqack;
    logic                      w_respcyc;
    logic [BUS_DATA_WIDTH-1:0] w_resp;
    logic                      w_unused;

    // Word index is formed at full 64 bits so out-of-range lines never alias.
    assign w_word_idx  = (64'(r_base) >> c_WORD_SHIFT) + 64'(r_beat);
    assign w_is_read   = (r_tag[c_TAG_RW_BIT] == c_TAG_READ);
    assign w_mem_hit   = (r_tag[c_TAG_TYPE_MSB:c_TAG_TYPE_LSB] == c_TYPE_MEMORY)
                       && (w_word_idx < 64'(MEM_WORDS));
    assign w_last_beat = (r_beat == 3'(c_BEATS_PER_LINE - 1));
    assign w_lat_done  = (r_lat_cnt == c_LAT_W'(LATENCY - 1));
    assign w_rd_adv    = (r_state == c_ST_RESP) && bus.bus_respack;
    assign w_wr_adv    = (r_state == c_ST_WDATA) && bus.bus_reqcyc;
    assign w_mem_we    = w_wr_adv && w_mem_hit;
    assign w_unused    = ^r_tag[c_TAG_TYPE_LSB-1:0];

    sysbus_mem_array #(
        .DATA_WIDTH (BUS_DATA_WIDTH),
        .DEPTH      (MEM_WORDS),
        .ADDR_W     (c_ADDR_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_waddr (w_word_idx[c_ADDR_W-1:0]),
        .i_wdata (bus.bus_req),
        .i_raddr (w_word_idx[c_ADDR_W-1:0]),
        .o_rdata (w_mem_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE:  if (bus.bus_reqcyc) w_state_next = c_ST_ACK;
            c_ST_ACK:   w_state_next = w_is_read ? c_ST_WAIT : c_ST_WDATA;
            c_ST_WAIT:  if (w_lat_done) w_state_next = c_ST_RESP;
            c_ST_RESP:  if (w_rd_adv && w_last_beat) w_state_next = c_ST_IDLE;
            c_ST_WDATA: if (w_wr_adv && w_last_beat) w_state_next = c_ST_IDLE;
            default:    w_state_next = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_reqack  = (r_state == c_ST_ACK) || w_wr_adv;
        w_respcyc = (r_state == c_ST_RESP);
        w_resp    = (w_respcyc && w_mem_hit) ? w_mem_rdata : '0;
    end

    assign bus.bus_reqack  = w_reqack;
    assign bus.bus_respcyc = w_respcyc;
    assign bus.bus_resp    = w_resp;
    assign bus.bus_resptag = r_tag;

    // Beat counter wraps 7 -> 0 on the final beat, leaving it clean for the next line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_base    <= '0;
            r_tag     <= '0;
            r_beat    <= '0;
            r_lat_cnt <= '0;
        end else begin
            if ((r_state == c_ST_IDLE) && bus.bus_reqcyc) begin
                r_base    <= {bus.bus_req[BUS_DATA_WIDTH-1:c_LINE_OFFSET_BITS],
                              c_LINE_OFFSET_BITS'(0)};
                r_tag     <= bus.bus_reqtag;
                r_beat    <= '0;
                r_lat_cnt <= '0;
            end
            if (r_state == c_ST_WAIT) begin
                r_lat_cnt <= w_lat_done ? '0 : r_lat_cnt + 1'b1;
            end
            if (w_rd_adv || w_wr_adv) begin
                r_beat <= r_beat + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire
